// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer for a 3-in/2-out combinational block.
// Drives every input vector, captures outputs and scores them against tables.
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXP_Y0        = 8'hE0,
    parameter logic [7:0]  EXP_Y1        = 8'h11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       ack,
    output logic [2:0] x_out,
    input  logic [1:0] y_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt_y0,
    output logic [7:0] tt_y1,
    output logic [7:0] mismatch_mask,
    output logic [4:0] mismatch_cnt,
    output logic       pass
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("tt_sweep_ctrl: SETTLE_CYCLES must be 1..15");
    end

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] wait_q, wait_d;
    logic [2:0] x_q, x_d;
    logic [7:0] t0_q, t0_d;
    logic [7:0] t1_q, t1_d;
    logic [7:0] mask_q, mask_d;
    logic [4:0] mcnt_q, mcnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       e0, e1;

    assign e0 = y_in[0] ^ EXP_Y0[idx_q];
    assign e1 = y_in[1] ^ EXP_Y1[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        x_d     = x_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        mask_d  = mask_q;
        mcnt_d  = mcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    idx_d   = 3'd0;
                    x_d     = 3'd0;
                    wait_d  = RELOAD;
                    t0_d    = 8'h00;
                    t1_d    = 8'h00;
                    mask_d  = 8'h00;
                    mcnt_d  = 5'd0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    x_d     = 3'd0;
                end else if (wait_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            SAMPLE: begin
                // Capture happens even when abort coincides with this cycle.
                t0_d[idx_q]   = y_in[0];
                t1_d[idx_q]   = y_in[1];
                mask_d[idx_q] = e0 | e1;
                mcnt_d        = mcnt_q + {4'd0, e0} + {4'd0, e1};
                if (abort) begin
                    state_d = IDLE;
                    x_d     = 3'd0;
                end else if (idx_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    state_d = SETTLE;
                    idx_d   = idx_q + 3'd1;
                    x_d     = idx_q + 3'd1;
                    wait_d  = RELOAD;
                end
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                    x_d     = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
                x_d     = 3'd0;
            end
        endcase
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        pass_d = done_d && (mcnt_d == 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            wait_q  <= 4'd0;
            x_q     <= 3'd0;
            t0_q    <= 8'h00;
            t1_q    <= 8'h00;
            mask_q  <= 8'h00;
            mcnt_q  <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            x_q     <= x_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            mask_q  <= mask_d;
            mcnt_q  <= mcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign x_out         = x_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign tt_y0         = t0_q;
    assign tt_y1         = t1_q;
    assign mismatch_mask = mask_q;
    assign mismatch_cnt  = mcnt_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl with a scoreboard of expected sweep results.
// A behavioural logic block (good or faulty) closes the loop from x_out to y_in.
module tb_tt_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ack = 1'b0;
    logic [2:0] x_out;
    logic [1:0] y_in;
    logic       busy, done, pass;
    logic [7:0] tt_y0, tt_y1, mismatch_mask;
    logic [4:0] mismatch_cnt;

    int ntests = 0;
    int nfail = 0;
    int mode = 0;

    typedef struct {
        logic [7:0] t0;
        logic [7:0] t1;
        logic [7:0] mk;
        logic [4:0] cnt;
        logic       ps;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    tt_sweep_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .ack          (ack),
        .x_out        (x_out),
        .y_in         (y_in),
        .busy         (busy),
        .done         (done),
        .tt_y0        (tt_y0),
        .tt_y1        (tt_y1),
        .mismatch_mask(mismatch_mask),
        .mismatch_cnt (mismatch_cnt),
        .pass         (pass)
    );

    function automatic logic [1:0] model(input int m, input logic [2:0] x);
        logic [1:0] y;
        y[0] = x[2] & (x[0] | x[1]);
        y[1] = ~x[0] & ~x[1];
        if (m == 1) y[0] = 1'b0;
        if (m == 2 && x == 3'd5) y = ~y;
        return y;
    endfunction

    always_comb y_in = model(mode, x_out);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected results of the first nvec vectors under model m.
    task automatic push_exp(input int m, input int nvec);
        exp_t e;
        logic [1:0] y, r;
        e = '{8'h00, 8'h00, 8'h00, 5'd0, 1'b0};
        for (int i = 0; i < nvec; i++) begin
            y = model(m, 3'(i));
            r = model(0, 3'(i));
            e.t0[i] = y[0];
            e.t1[i] = y[1];
            e.mk[i] = |(y ^ r);
            e.cnt = e.cnt + 5'(y[0] ^ r[0]) + 5'(y[1] ^ r[1]);
        end
        e.ps = (nvec == 8) && (e.cnt == 5'd0);
        sbq.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        chk({tag, "_sb_size"}, sbq.size(), 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_tt_y0"}, tt_y0, e.t0);
            chk({tag, "_tt_y1"}, tt_y1, e.t1);
            chk({tag, "_mask"}, mismatch_mask, e.mk);
            chk({tag, "_cnt"}, mismatch_cnt, e.cnt);
            chk({tag, "_pass"}, pass, e.ps);
        end
    endtask

    // Full sweep: start, optional x stepping check, optional re-start pulse,
    // check done latency and results, then ack (optionally with start).
    task automatic sweep(input string tag, input int m, input bit chk_x,
                         input int restart_at, input bit start_with_ack);
        int n;
        mode = m;
        push_exp(m, 8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            if (chk_x && n < 24) chk({tag, "_x_step"}, x_out, n / 3);
            if (n == restart_at) start = 1'b1;
            else start = 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, "_done_edge"}, n, 24);
        chk({tag, "_x_done"}, x_out, 7);
        chk({tag, "_busy_done"}, busy, 0);
        pop_chk(tag);
        ack = 1'b1;
        start = start_with_ack;
        @(negedge clk);
        ack = 1'b0;
        start = 1'b0;
        chk({tag, "_ack_done"}, done, 0);
        chk({tag, "_ack_pass"}, pass, 0);
        chk({tag, "_ack_x"}, x_out, 0);
        chk({tag, "_ack_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        exp_t e;
        #12;
        chk("rst_x", x_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_tables", {tt_y0, tt_y1, mismatch_mask}, 0);
        chk("rst_cnt", mismatch_cnt, 0);
        rst_n = 1'b1;

        sweep("good", 0, 1'b1, -1, 1'b0);
        chk("idle_keep_tt0", tt_y0, 8'hE0);
        chk("idle_keep_tt1", tt_y1, 8'h11);

        sweep("stuck0", 1, 1'b0, -1, 1'b0);
        sweep("inv5", 2, 1'b0, -1, 1'b0);

        sweep("restart", 0, 1'b0, 9, 1'b1);
        repeat (5) @(negedge clk);
        chk("restart_no_second_busy", busy, 0);
        chk("restart_no_second_done", done, 0);

        // Abort in SETTLE of vector 4.
        mode = 0;
        push_exp(0, 4);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 12; n++) @(negedge clk);
        chk("abort_pre_x", x_out, 4);
        chk("abort_pre_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_x", x_out, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        e = sbq[0];
        pop_chk("abort");
        repeat (30) @(negedge clk);
        chk("abort_done_never", done, 0);
        chk("abort_tt0_kept", tt_y0, e.t0);

        // Asynchronous reset during vector 6.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 19; n++) @(negedge clk);
        chk("arst_pre_x", x_out, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x", x_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tables", {tt_y0, tt_y1, mismatch_mask}, 0);
        chk("arst_cnt", mismatch_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_hold_busy", busy, 0);

        sweep("after_rst", 0, 1'b1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
